stopwatch_ctrl: RTL and testbench

- Timing and mode controller for the 4-digit mm:ss stopwatch.
- Debounces the pause button and synchronises the ADJ/SEL switches.
- Runs the RUN/PAUSE/ADJUST state machine and produces registered enable pulses for the minutes/seconds counter datapath, a blink phase, and the digit-scan select for the 7-segment mux.
- Sits between the raw board inputs and the counter/display blocks inside the stopwatch top level.

---
 rtl/stopwatch_ctrl_if.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Board-side controls into the stopwatch controller and its
// enable/blink/scan/mode outputs toward the counter and display blocks.
interface stopwatch_ctrl_if;
  logic       btn_pause;
  logic       sw_adj;
  logic       sw_sel;
  logic       cnt_en;
  logic       adj_sec;
  logic       adj_min;
  logic       blink_sec;
  logic       blink_min;
  logic [1:0] scan_sel;
  logic [3:0] an;
  logic [1:0] mode;

  modport master (
    output btn_pause, sw_adj, sw_sel,
    input  cnt_en, adj_sec, adj_min,
    input  blink_sec, blink_min,
    input  scan_sel, an, mode
  );

  modport slave (
    input  btn_pause, sw_adj, sw_sel,
    output cnt_en, adj_sec, adj_min,
    output blink_sec, blink_min,
    output scan_sel, an, mode
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Input conditioning, RUN/PAUSE/ADJUST control, tick and scan generation
// for the mm:ss stopwatch.
module stopwatch_ctrl #(
  parameter int unsigned DIV_1HZ   = 100000000,
  parameter int unsigned DIV_2HZ   = 50000000,
  parameter int unsigned DIV_SCAN  = 100000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);
  localparam int unsigned W1 = $clog2(DIV_1HZ + 1);
  localparam int unsigned W2 = $clog2(DIV_2HZ + 1);
  localparam int unsigned WS = $clog2(DIV_SCAN + 1);
  localparam int unsigned WD = $clog2(DB_CYCLES + 1);

  localparam logic [W1-1:0] TOP1 = W1'(DIV_1HZ - 1);
  localparam logic [W2-1:0] TOP2 = W2'(DIV_2HZ - 1);
  localparam logic [WS-1:0] TOPS = WS'(DIV_SCAN - 1);
  localparam logic [WD-1:0] TOPD = WD'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSE  = 2'b01,
    ADJUST = 2'b10
  } mode_e;

  logic [1:0]    btn_s_q, adj_s_q, sel_s_q;
  logic          sync_btn, sync_adj, sync_sel;
  logic [WD-1:0] db_cnt_q, db_cnt_d;
  logic          db_lvl_q, db_lvl_d;
  logic          press;
  mode_e         mode_q, mode_d;
  logic          pause_q, pause_d;
  logic [W1-1:0] div1_q, div1_d;
  logic [W2-1:0] div2_q, div2_d;
  logic [WS-1:0] divs_q, divs_d;
  logic          tick_1hz, tick_2hz, tick_scan;
  logic          run, adj;
  logic          phase_q, phase_d;
  logic [1:0]    scan_q, scan_d;
  logic [3:0]    an_q, an_d;
  logic          cnt_en_q, adj_sec_q, adj_min_q;
  logic          blink_sec_q, blink_min_q;

  assign sync_btn = btn_s_q[1];
  assign sync_adj = adj_s_q[1];
  assign sync_sel = sel_s_q[1];

  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    press    = 1'b0;
    if (sync_btn != db_lvl_q) begin
      if (db_cnt_q == TOPD) begin
        db_lvl_d = sync_btn;
        press    = sync_btn;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign run = (mode_q == RUN);
  assign adj = (mode_q == ADJUST);

  // 1 Hz divider is parked at zero outside RUN so a resume waits a full second
  assign tick_1hz  = run && (div1_q == TOP1);
  assign div1_d    = (!run || tick_1hz) ? '0 : div1_q + 1'b1;
  assign tick_2hz  = (div2_q == TOP2);
  assign div2_d    = tick_2hz ? '0 : div2_q + 1'b1;
  assign tick_scan = (divs_q == TOPS);
  assign divs_d    = tick_scan ? '0 : divs_q + 1'b1;

  assign phase_d = phase_q ^ tick_2hz;
  assign scan_d  = scan_q + {1'b0, tick_scan};
  assign an_d    = ~(4'b0001 << scan_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= RUN;
      pause_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pause_q <= pause_d;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    pause_d = pause_q;
    unique case (mode_q)
      RUN, PAUSE: begin
        if (sync_adj) begin
          mode_d = ADJUST;
        end else if (press) begin
          pause_d = ~pause_q;
          mode_d  = pause_q ? RUN : PAUSE;
        end
      end
      ADJUST: begin
        if (!sync_adj) mode_d = pause_q ? PAUSE : RUN;
      end
      default: mode_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s_q     <= '0;
      adj_s_q     <= '0;
      sel_s_q     <= '0;
      db_cnt_q    <= '0;
      db_lvl_q    <= 1'b0;
      div1_q      <= '0;
      div2_q      <= '0;
      divs_q      <= '0;
      phase_q     <= 1'b0;
      scan_q      <= 2'd0;
      an_q        <= 4'b1110;
      cnt_en_q    <= 1'b0;
      adj_sec_q   <= 1'b0;
      adj_min_q   <= 1'b0;
      blink_sec_q <= 1'b0;
      blink_min_q <= 1'b0;
    end else begin
      btn_s_q     <= {btn_s_q[0], bus.btn_pause};
      adj_s_q     <= {adj_s_q[0], bus.sw_adj};
      sel_s_q     <= {sel_s_q[0], bus.sw_sel};
      db_cnt_q    <= db_cnt_d;
      db_lvl_q    <= db_lvl_d;
      div1_q      <= div1_d;
      div2_q      <= div2_d;
      divs_q      <= divs_d;
      phase_q     <= phase_d;
      scan_q      <= scan_d;
      an_q        <= an_d;
      cnt_en_q    <= tick_1hz;
      adj_sec_q   <= tick_2hz & adj & sync_sel;
      adj_min_q   <= tick_2hz & adj & ~sync_sel;
      blink_sec_q <= adj & sync_sel & phase_q;
      blink_min_q <= adj & ~sync_sel & phase_q;
    end
  end

  assign bus.cnt_en    = cnt_en_q;
  assign bus.adj_sec   = adj_sec_q;
  assign bus.adj_min   = adj_min_q;
  assign bus.blink_sec = blink_sec_q;
  assign bus.blink_min = blink_min_q;
  assign bus.scan_sel  = scan_q;
  assign bus.an        = an_q;
  assign bus.mode      = mode_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button/switch
// activity, compared every cycle against a cycle-count reference model.
module tb_stopwatch_ctrl;
  localparam int D1 = 10;
  localparam int D2 = 5;
  localparam int DS = 2;
  localparam int DB = 4;
  localparam int M_RUN = 0;
  localparam int M_PAUSE = 1;
  localparam int M_ADJ = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(
    .DIV_1HZ  (D1),
    .DIV_2HZ  (D2),
    .DIV_SCAN (DS),
    .DB_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: elapsed-cycle arithmetic and a mode/pause-flag record
  bit [1:0] m_bsh, m_ash, m_ssh;
  bit       m_lvl, m_pz, m_ph;
  int       m_diff, m_mode, m_run, m_free, m_scan;
  bit       e_cnt, e_asec, e_amin, e_bsec, e_bmin;

  always @(posedge clk or posedge rst) begin
    bit sb, sa, sl, prs, t1, t2, ts;
    if (rst) begin
      m_bsh = '0; m_ash = '0; m_ssh = '0;
      m_lvl = 0; m_pz = 0; m_ph = 0;
      m_diff = 0; m_mode = M_RUN; m_run = 0; m_free = 0; m_scan = 0;
      e_cnt = 0; e_asec = 0; e_amin = 0; e_bsec = 0; e_bmin = 0;
    end else begin
      sb = m_bsh[1]; sa = m_ash[1]; sl = m_ssh[1];
      prs = 0;
      if (sb != m_lvl) m_diff++;
      else m_diff = 0;
      if (m_diff == DB) begin
        m_lvl = sb; m_diff = 0; prs = sb;
      end
      t1 = (m_mode == M_RUN) && (m_run % D1 == D1 - 1);
      t2 = (m_free % D2 == D2 - 1);
      ts = (m_free % DS == DS - 1);
      e_cnt  = t1;
      e_asec = t2 && m_mode == M_ADJ && sl;
      e_amin = t2 && m_mode == M_ADJ && !sl;
      e_bsec = m_mode == M_ADJ && sl && m_ph;
      e_bmin = m_mode == M_ADJ && !sl && m_ph;
      if (t2) m_ph = !m_ph;
      if (ts) m_scan = (m_scan + 1) % 4;
      m_free++;
      m_run = (m_mode == M_RUN) ? m_run + 1 : 0;
      if (m_mode == M_ADJ) begin
        if (!sa) m_mode = m_pz ? M_PAUSE : M_RUN;
      end else if (sa) begin
        m_mode = M_ADJ;
      end else if (prs) begin
        m_pz = !m_pz;
        m_mode = m_pz ? M_PAUSE : M_RUN;
      end
      m_bsh = {m_bsh[0], bus.btn_pause};
      m_ash = {m_ash[0], bus.sw_adj};
      m_ssh = {m_ssh[0], bus.sw_sel};
    end
  end

  always @(negedge clk) begin
    logic [3:0] ean;
    if (chk_on) begin
      ean = 4'hF;
      ean[m_scan] = 1'b0;
      chk("pulses", 16'({bus.cnt_en, bus.adj_sec, bus.adj_min}),
          16'({e_cnt, e_asec, e_amin}));
      chk("blink", 16'({bus.blink_sec, bus.blink_min}), 16'({e_bsec, e_bmin}));
      chk("scan_an", 16'({bus.scan_sel, bus.an}), 16'({m_scan[1:0], ean}));
      chk("mode", 16'(bus.mode), 16'(m_mode[1:0]));
      chk("one_pulse",
          16'($countones({bus.cnt_en, bus.adj_sec, bus.adj_min}) <= 1), 16'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input int hi, input int lo);
    bus.btn_pause = 1'b1;
    cyc(hi);
    bus.btn_pause = 1'b0;
    cyc(lo);
  endtask

  task automatic count(input int n, output int c_cnt,
                       output int c_as, output int c_am);
    c_cnt = 0; c_as = 0; c_am = 0;
    repeat (n) begin
      @(negedge clk);
      c_cnt += int'(bus.cnt_en);
      c_as  += int'(bus.adj_sec);
      c_am  += int'(bus.adj_min);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_pulses"}, 16'({bus.cnt_en, bus.adj_sec, bus.adj_min}), 16'd0);
    chk({tag, "_blink"}, 16'({bus.blink_sec, bus.blink_min}), 16'd0);
    chk({tag, "_scan"}, 16'(bus.scan_sel), 16'd0);
    chk({tag, "_an"}, 16'(bus.an), 16'hE);
    chk({tag, "_mode"}, 16'(bus.mode), 16'd0);
  endtask

  initial begin
    int c1, c2, c3, k;
    bus.btn_pause = 1'b0;
    bus.sw_adj = 1'b0;
    bus.sw_sel = 1'b0;
    #1 rst = 1'b1;
    #2 chk_on = 1'b1;
    cyc(3);
    chk_rst_vals("rst");
    rst = 1'b0;

    count(35, c1, c2, c3);
    chk("idle_cnt_en", 16'(c1), 16'd3);
    chk("idle_mode", 16'(bus.mode), 16'd0);

    press_btn(2, 10);
    chk("short_press_mode", 16'(bus.mode), 16'd0);
    press_btn(8, 6);
    chk("long_press_mode", 16'(bus.mode), 16'd1);
    count(30, c1, c2, c3);
    chk("pause_cnt_en", 16'(c1), 16'd0);
    press_btn(8, 6);
    chk("resume_mode", 16'(bus.mode), 16'd0);

    bus.sw_sel = 1'b1;
    bus.sw_adj = 1'b1;
    count(20, c1, c2, c3);
    chk("adj_mode", 16'(bus.mode), 16'd2);
    chk("adj_sec_n", 16'(c2 >= 3), 16'd1);
    chk("adj_min_n", 16'(c3), 16'd0);
    bus.sw_sel = 1'b0;
    count(15, c1, c2, c3);
    chk("adj_min_n2", 16'(c3 >= 2), 16'd1);
    bus.sw_adj = 1'b0;
    cyc(5);
    chk("exit_to_run", 16'(bus.mode), 16'd0);

    press_btn(8, 6);
    bus.sw_adj = 1'b1;
    cyc(8);
    chk("adj_from_pause", 16'(bus.mode), 16'd2);
    press_btn(8, 8);
    bus.sw_adj = 1'b0;
    cyc(5);
    chk("exit_to_pause", 16'(bus.mode), 16'd1);
    press_btn(8, 6);
    chk("back_to_run", 16'(bus.mode), 16'd0);

    bus.sw_adj = 1'b1;
    cyc(12);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_rst_vals("mid_rst");
    bus.sw_adj = 1'b0;
    cyc(2);
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (bus.cnt_en) k = i;
    end
    chk("first_cnt_after_rst", 16'(k), 16'd10);

    // debounce completes on the same cycle the synchronised ADJ rises
    bus.btn_pause = 1'b1;
    cyc(3);
    bus.sw_adj = 1'b1;
    cyc(10);
    chk("press_adj_mode", 16'(bus.mode), 16'd2);
    bus.btn_pause = 1'b0;
    cyc(10);
    bus.sw_adj = 1'b0;
    cyc(5);
    chk("press_adj_exit", 16'(bus.mode), 16'd0);

    repeat (60) begin
      case ($urandom_range(0, 5))
        0, 1: press_btn($urandom_range(1, 10), $urandom_range(5, 15));
        2: begin
          bus.sw_adj = ~bus.sw_adj;
          cyc($urandom_range(10, 25));
        end
        3: begin
          bus.sw_sel = 1'($urandom);
          cyc($urandom_range(3, 12));
        end
        default: cyc($urandom_range(5, 20));
      endcase
    end
    bus.sw_adj = 1'b0;
    bus.btn_pause = 1'b0;
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
